phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 132 +++++++++++++
 tb/tb_phase_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Run/stop/single-step sequencer producing the phase number and one-hot phase enables.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_CNT_EN.
module phase_sequencer #(
    parameter int NUM_PHASES = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec_lvl,
    input  logic             step_lvl,
    input  logic             hlt_dec,
    output logic [2:0]       phase,
    output logic [7:0]       phase_en,
    output logic             active,
    output logic             halted,
    output logic             retire
`ifdef SEQ_INSTR_CNT_EN
    ,
    output logic [CNT_W-1:0] instr_count
`endif
);

    if (NUM_PHASES < 2 || NUM_PHASES > 8 || CNT_W < 1) begin : g_bad_param
        $error("phase_sequencer: NUM_PHASES must be 2..8 and CNT_W >= 1");
    end

    localparam logic [2:0] LAST_PH = 3'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STEP,
        HALTED
    } state_t;

    state_t     state, state_d;
    logic [2:0] phase_d;
    logic [7:0] phase_en_d;
    logic       exec_q, step_q;
    logic       exec_p, step_p;
    logic       hlt_seen, hlt_seen_d;
    logic       stop_pend, stop_pend_d;
    logic       boundary;
    logic       hlt_eff, stop_eff;

    assign exec_p   = exec_lvl & ~exec_q;
    assign step_p   = step_lvl & ~step_q;
    assign active   = (state == RUN) || (state == STEP);
    assign halted   = (state == HALTED);
    assign boundary = active && (phase == LAST_PH);
    assign retire   = boundary;

    // Flags raised in the boundary cycle itself still count, so a two-phase
    // instruction (HLT decodable only in its last phase) can halt.
    assign hlt_eff  = hlt_seen | (hlt_dec & (phase != '0));
    assign stop_eff = stop_pend | exec_p;

    always_comb begin
        state_d     = state;
        phase_d     = phase;
        hlt_seen_d  = hlt_seen;
        stop_pend_d = stop_pend;
        case (state)
            IDLE, HALTED: begin
                phase_d = '0;
                if (exec_p) begin
                    state_d = RUN;
                end else if (step_p) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                if (hlt_dec && (phase != '0)) begin
                    hlt_seen_d = 1'b1;
                end
                if ((state == RUN) && exec_p) begin
                    stop_pend_d = 1'b1;
                end
                if (boundary) begin
                    phase_d     = '0;
                    hlt_seen_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    if (hlt_eff) begin
                        state_d = HALTED;
                    end else if ((state == STEP) || stop_eff) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    phase_d = phase + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
        phase_en_d = ((state_d == RUN) || (state_d == STEP)) ? (8'b1 << phase_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            phase_en  <= '0;
            exec_q    <= 1'b1;
            step_q    <= 1'b1;
            hlt_seen  <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            phase_en  <= phase_en_d;
            exec_q    <= exec_lvl;
            step_q    <= step_lvl;
            hlt_seen  <= hlt_seen_d;
            stop_pend <= stop_pend_d;
        end
    end

`ifdef SEQ_INSTR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: the driver queues hand-derived expected
// outputs per cycle, an independent monitor pops and compares on the falling edge.
module tb_phase_sequencer;

    localparam int NP = 5;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        exec_lvl = 1'b1;
    logic        step_lvl = 1'b0;
    logic        hlt_dec  = 1'b0;
    logic [2:0]  phase;
    logic [7:0]  phase_en;
    logic        active;
    logic        halted;
    logic        retire;
`ifdef SEQ_INSTR_CNT_EN
    logic [31:0] instr_count;
`endif

    phase_sequencer #(
        .NUM_PHASES(NP),
        .CNT_W     (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exec_lvl   (exec_lvl),
        .step_lvl   (step_lvl),
        .hlt_dec    (hlt_dec),
        .phase      (phase),
        .phase_en   (phase_en),
        .active     (active),
        .halted     (halted),
        .retire     (retire)
`ifdef SEQ_INSTR_CNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {S_IDLE, S_RUN, S_STEP, S_HALT} st_t;

    typedef struct packed {
        logic [2:0]  ph;
        logic [7:0]  en;
        logic        act;
        logic        hlt;
        logic        ret;
        logic [31:0] cnt;
    } outs_t;

    typedef struct {
        string name;
        outs_t v;
    } item_t;

    item_t       q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_cnt     = '0;

    task automatic cyc(input logic r, input logic e, input logic s, input logic h,
                       input st_t st, input int ph, input string nm);
        item_t it;
        @(negedge clk);
        rst      = r;
        exec_lvl = e;
        step_lvl = s;
        hlt_dec  = h;
        @(posedge clk);
        it.name  = nm;
        it.v.ph  = 3'(ph);
        it.v.act = (st == S_RUN) || (st == S_STEP);
        it.v.en  = it.v.act ? 8'(1 << ph) : 8'h00;
        it.v.hlt = (st == S_HALT);
        it.v.ret = it.v.act && (ph == NP - 1);
        if (r) exp_cnt = '0;
`ifdef SEQ_INSTR_CNT_EN
        it.v.cnt = exp_cnt;
`else
        it.v.cnt = '0;
`endif
        q.push_back(it);
        if (it.v.ret) exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin : monitor
        item_t it;
        outs_t got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                got.ph  = phase;
                got.en  = phase_en;
                got.act = active;
                got.hlt = halted;
                got.ret = retire;
`ifdef SEQ_INSTR_CNT_EN
                got.cnt = instr_count;
`else
                got.cnt = '0;
`endif
                vectors++;
                if (got !== it.v) begin
                    miscompares++;
                    $display("FAIL %s: got ph=%0d en=%h act=%b hlt=%b ret=%b cnt=%0d, want ph=%0d en=%h act=%b hlt=%b ret=%b cnt=%0d",
                             it.name, got.ph, got.en, got.act, got.hlt, got.ret, got.cnt,
                             it.v.ph, it.v.en, it.v.act, it.v.hlt, it.v.ret, it.v.cnt);
                end
            end
        end
    end

    initial begin : driver
        // Reset with exec held; holding it afterwards must not start the core
        cyc(1, 1, 0, 0, S_IDLE, 0, "rst_a");
        cyc(1, 1, 0, 0, S_IDLE, 0, "rst_b");
        repeat (5) cyc(0, 1, 0, 0, S_IDLE, 0, "held_exec");
        cyc(0, 0, 0, 0, S_IDLE, 0, "release");
        cyc(0, 1, 0, 0, S_RUN, 0, "start");
        for (int i = 1; i < 12; i++) cyc(0, 1, 0, 0, S_RUN, i % NP, "run_seq");

        // Stop request in phase 2 finishes the instruction
        cyc(0, 0, 0, 0, S_RUN, 2, "run_p2");
        cyc(0, 1, 0, 0, S_RUN, 3, "stop_req");
        cyc(0, 0, 0, 0, S_RUN, 4, "stop_last");
        cyc(0, 0, 0, 0, S_IDLE, 0, "stopped");
        cyc(0, 0, 0, 0, S_IDLE, 0, "idle_hold");

        // HLT in phase 1, resume, HLT in phase 0 ignored
        cyc(0, 1, 0, 0, S_RUN, 0, "t4_start");
        cyc(0, 0, 0, 0, S_RUN, 1, "t4_p1");
        cyc(0, 0, 0, 1, S_RUN, 2, "hlt_p1");
        cyc(0, 0, 0, 0, S_RUN, 3, "hlt_p3");
        cyc(0, 0, 0, 0, S_RUN, 4, "hlt_p4");
        cyc(0, 0, 0, 0, S_HALT, 0, "halted");
        cyc(0, 0, 0, 0, S_HALT, 0, "halt_hold");
        cyc(0, 1, 0, 0, S_RUN, 0, "resume");
        cyc(0, 0, 0, 1, S_RUN, 1, "hlt_p0_ign");
        cyc(0, 1, 0, 0, S_RUN, 2, "stop2");
        cyc(0, 0, 0, 0, S_RUN, 3, "stop2_p3");
        cyc(0, 0, 0, 0, S_RUN, 4, "stop2_p4");
        cyc(0, 0, 0, 0, S_IDLE, 0, "stop2_idle");

        // Single step from IDLE
        cyc(0, 0, 1, 0, S_STEP, 0, "step");
        for (int i = 1; i < NP; i++) cyc(0, 0, 0, 0, S_STEP, i, "step_seq");
        cyc(0, 0, 0, 0, S_IDLE, 0, "step_idle");

        // Step ignored in RUN
        cyc(0, 1, 0, 0, S_RUN, 0, "run3");
        cyc(0, 0, 1, 0, S_RUN, 1, "step_in_run");
        cyc(0, 0, 0, 0, S_RUN, 2, "run3_p2");
        cyc(0, 1, 0, 0, S_RUN, 3, "stop3");
        cyc(0, 0, 0, 0, S_RUN, 4, "stop3_p4");
        cyc(0, 0, 0, 0, S_IDLE, 0, "stop3_idle");

        // Exec ignored in STEP
        cyc(0, 0, 1, 0, S_STEP, 0, "step2");
        cyc(0, 1, 0, 0, S_STEP, 1, "exec_in_step");
        cyc(0, 0, 0, 0, S_STEP, 2, "step2_p2");
        cyc(0, 0, 0, 0, S_STEP, 3, "step2_p3");
        cyc(0, 0, 0, 0, S_STEP, 4, "step2_p4");
        cyc(0, 0, 0, 0, S_IDLE, 0, "step2_idle");

        // Simultaneous exec and step: exec wins
        cyc(0, 1, 1, 0, S_RUN, 0, "both");
        cyc(0, 0, 0, 0, S_RUN, 1, "both_p1");
        cyc(0, 1, 0, 0, S_RUN, 2, "both_stop");
        cyc(0, 0, 0, 0, S_RUN, 3, "both_p3");
        cyc(0, 0, 0, 0, S_RUN, 4, "both_p4");
        cyc(0, 0, 0, 0, S_IDLE, 0, "both_idle");

        // HLT during STEP, then step out of HALTED
        cyc(0, 0, 1, 0, S_STEP, 0, "step3");
        cyc(0, 0, 0, 0, S_STEP, 1, "step3_p1");
        cyc(0, 0, 0, 1, S_STEP, 2, "hlt_step");
        cyc(0, 0, 0, 0, S_STEP, 3, "step3_p3");
        cyc(0, 0, 0, 0, S_STEP, 4, "step3_p4");
        cyc(0, 0, 0, 0, S_HALT, 0, "step_halted");
        cyc(0, 0, 1, 0, S_STEP, 0, "step_from_halt");
        for (int i = 1; i < NP; i++) cyc(0, 0, 0, 0, S_STEP, i, "sfh_seq");
        cyc(0, 0, 0, 0, S_IDLE, 0, "sfh_idle");

        // Reset in phase 3 discards the instruction
        cyc(0, 1, 0, 0, S_RUN, 0, "t6_start");
        cyc(0, 0, 0, 0, S_RUN, 1, "t6_p1");
        cyc(0, 0, 0, 0, S_RUN, 2, "t6_p2");
        cyc(0, 0, 0, 0, S_RUN, 3, "t6_p3");
        cyc(1, 0, 0, 0, S_IDLE, 0, "rst_mid");
        cyc(0, 0, 0, 0, S_IDLE, 0, "post_rst");

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
